// File: rtl/downstream_pkg.sv
// Shared types, default parameters and the round-robin pick helper for the
// downstream update controller.
package downstream_pkg;

  // One-hot FSM encoding; any other pattern is treated as illegal.
  typedef enum logic [1:0] {
    IDLE       = 2'b01,
    UPDATE_MEM = 2'b10
  } state_t;

  localparam int DEF_NUM_CH  = 4;
  localparam int DEF_ADDR_W  = 16;
  localparam int DEF_DATA_W  = 32;
  localparam int DEF_TIMEOUT = 15;
  localparam int DEF_CNT_W   = 16;

  // Upper bound on channel count; the pick helper works on a padded vector.
  localparam int MAX_CH    = 16;
  localparam int TIMER_W   = 8;

  // First set bit of valid searching upward from ptr, wrapping modulo num_ch.
  // Returns ptr when nothing is set (caller qualifies with |valid).
  function automatic logic [3:0] rr_pick(input logic [MAX_CH-1:0] valid,
                                         input logic [3:0] ptr,
                                         input int num_ch);
    logic [3:0] result;
    logic       found;
    int         idx;
    result = ptr;
    found  = 1'b0;
    for (int k = 0; k < MAX_CH; k++) begin
      idx = int'(ptr) + k;
      if (idx >= num_ch) idx = idx - num_ch;
      if (!found && (k < num_ch) && valid[idx[3:0]]) begin
        found  = 1'b1;
        result = idx[3:0];
      end
    end
    return result;
  endfunction

endpackage

// File: rtl/downstream_update_ctrl_rr_arbiter.sv
// Round-robin arbiter: combinational pick plus the priority pointer, which
// moves to the channel after the one just serviced when advance is strobed.
module rr_arbiter
  import downstream_pkg::*;
#(
  parameter int NUM_CH = DEF_NUM_CH,
  parameter int IDX_W  = (NUM_CH > 1) ? $clog2(NUM_CH) : 1
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic [NUM_CH-1:0] valid,
  input  logic              advance,
  input  logic [IDX_W-1:0]  current,
  output logic [IDX_W-1:0]  pick,
  output logic              any
);

  logic [IDX_W-1:0]  rr_ptr;
  logic [MAX_CH-1:0] valid_ext;
  logic [3:0]        pick_wide;

  // Pad the request vector and search from the current priority pointer.
  always_comb begin
    valid_ext               = '0;
    valid_ext[NUM_CH-1:0]   = valid;
    pick_wide               = rr_pick(valid_ext, 4'(rr_ptr), NUM_CH);
    pick                    = pick_wide[IDX_W-1:0];
    any                     = |valid;
  end

  // Priority pointer: after each finished update, start at the next channel.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      rr_ptr <= '0;
    end else if (advance) begin
      rr_ptr <= (current == IDX_W'(NUM_CH - 1)) ? '0 : current + 1'b1;
    end
  end

endmodule

// File: rtl/downstream_update_ctrl.sv
// Multi-channel downstream update controller: arbitrates channel requests
// round-robin and holds one memory write until done or timeout.
module downstream_update_ctrl
  import downstream_pkg::*;
#(
  parameter int NUM_CH  = DEF_NUM_CH,
  parameter int ADDR_W  = DEF_ADDR_W,
  parameter int DATA_W  = DEF_DATA_W,
  parameter int TIMEOUT = DEF_TIMEOUT,
  parameter int CNT_W   = DEF_CNT_W,
  parameter int IDX_W   = (NUM_CH > 1) ? $clog2(NUM_CH) : 1
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic [NUM_CH-1:0]        ack_valid,
  output logic [NUM_CH-1:0]        ack_ready,
  input  logic [NUM_CH*ADDR_W-1:0] ack_addr,
  input  logic [NUM_CH*DATA_W-1:0] ack_data,
  output logic                     mem_wr_en,
  output logic [ADDR_W-1:0]        mem_addr,
  output logic [DATA_W-1:0]        mem_data,
  input  logic                     mem_wr_done,
  output logic                     busy,
  output logic [IDX_W-1:0]         grant_id,
  output logic                     timeout_err,
  output logic [CNT_W-1:0]         upd_count
);

  state_t             state, next_state;
  logic [TIMER_W-1:0] timer;
  logic [IDX_W-1:0]   pick;
  logic               any;
  logic               accept, succeed, expire, advance;

  rr_arbiter #(.NUM_CH(NUM_CH), .IDX_W(IDX_W)) u_arb (
    .clk     (clk),
    .rst_n   (rst_n),
    .valid   (ack_valid),
    .advance (advance),
    .current (grant_id),
    .pick    (pick),
    .any     (any)
  );

  // Next-state and handshake outputs; done wins over a same-cycle timeout.
  always_comb begin
    next_state = state;
    ack_ready  = '0;
    mem_wr_en  = 1'b0;
    busy       = 1'b0;
    accept     = 1'b0;
    succeed    = 1'b0;
    expire     = 1'b0;
    case (state)
      IDLE: begin
        if (any) begin
          accept     = 1'b1;
          ack_ready  = NUM_CH'(1) << pick;
          next_state = UPDATE_MEM;
        end
      end
      UPDATE_MEM: begin
        mem_wr_en = 1'b1;
        busy      = 1'b1;
        if (mem_wr_done) begin
          succeed    = 1'b1;
          next_state = IDLE;
        end else if (timer == TIMER_W'(TIMEOUT)) begin
          expire     = 1'b1;
          next_state = IDLE;
        end
      end
      default: next_state = IDLE;
    endcase
    advance = succeed | expire;
  end

  // State, capture registers, wait timer, success counter and sticky error.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state       <= IDLE;
      timer       <= '0;
      upd_count   <= '0;
      timeout_err <= 1'b0;
      mem_addr    <= '0;
      mem_data    <= '0;
      grant_id    <= '0;
    end else begin
      state <= next_state;
      case (state)
        IDLE: begin
          if (accept) begin
            mem_addr <= ack_addr[pick*ADDR_W +: ADDR_W];
            mem_data <= ack_data[pick*DATA_W +: DATA_W];
            grant_id <= pick;
            timer    <= '0;
          end
        end
        UPDATE_MEM: begin
          if (succeed) upd_count <= upd_count + 1'b1;
          else if (expire) timeout_err <= 1'b1;
          else timer <= timer + 1'b1;
        end
        default: begin
          timer    <= '0;
          mem_addr <= '0;
          mem_data <= '0;
          grant_id <= '0;
        end
      endcase
    end
  end

endmodule
